// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, issues them one at a time to an
// external fixed-latency ALU and returns captured results over a response handshake.
module alu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [3:0]               cmd_op,
    input  logic                     cmd_cin,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [3:0]               alu_op,
    output logic                     alu_cin,
    input  logic [31:0]              alu_out,
    input  logic                     alu_z,
    input  logic                     alu_v,
    input  logic                     alu_c,
    input  logic                     alu_n,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_out,
    output logic [3:0]               rsp_flags,
    output logic [3:0]               rsp_op,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(ALU_LAT - 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        cin;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    cmd_t          head;
    cmd_t          alu_q, alu_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rsp_out_q, rsp_out_d;
    logic [3:0]    rsp_flags_q, rsp_flags_d;
    logic [3:0]    rsp_op_q, rsp_op_d;
    logic          rsp_err_q, rsp_err_d;
    logic          push, pop;

    assign cmd_ready = count_q < FULL;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == IDLE && count_q != '0;
    assign head      = mem_q[rd_q];

    always_comb begin
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_d       = alu_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        if (push) begin
            mem_d[wr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op, cin: cmd_cin};
            wr_d        = wr_q + 1'b1;
        end
        if (pop)
            rd_d = rd_q + 1'b1;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE: if (pop) begin
                // Illegal ops never reach the ALU; they answer immediately with an error.
                if (head.op < 4'd14) begin
                    alu_d   = head;
                    cnt_d   = LAST;
                    state_d = WAIT;
                end else begin
                    rsp_err_d   = 1'b1;
                    rsp_out_d   = '0;
                    rsp_flags_d = '0;
                    rsp_op_d    = head.op;
                    state_d     = RESP;
                end
            end
            WAIT: if (cnt_q == '0) begin
                rsp_out_d   = alu_out;
                rsp_flags_d = {alu_n, alu_z, alu_v, alu_c};
                rsp_op_d    = alu_q.op;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        mem_q <= mem_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            alu_q       <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            alu_q       <= alu_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a      = alu_q.a;
    assign alu_b      = alu_q.b;
    assign alu_op     = alu_q.op;
    assign alu_cin    = alu_q.cin;
    assign rsp_valid  = state_q == RESP;
    assign rsp_out    = rsp_out_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = state_q != IDLE;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: drives alu_cmd_issuer against a pipelined stand-in ALU and checks
// every response against an in-order queue of expected results.
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_op = '0;
    logic        cmd_cin = 1'b0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_cin, alu_z, alu_v, alu_c, alu_n;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_out;
    logic [3:0]  rsp_flags, rsp_op;
    logic        rsp_err, busy;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [40:0] exp_q [$];
    logic acc;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    // Stand-in ALU result {N,Z,V,C,out}; ops 14/15 yield a poison value.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  r = a ^ b;
            4'd1:  r = a & b;
            4'd2:  r = a | b;
            4'd3:  r = ~(a | b);
            4'd4:  r = a;
            4'd5:  begin
                       s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
                       r = s[31:0]; c = s[32];
                       v = (a[31] == b[31]) && (r[31] != a[31]);
                   end
            4'd6:  r = ~a;
            4'd7:  begin
                       s = {1'b0, a} - {1'b0, b} - {32'b0, cin};
                       r = s[31:0]; c = s[32];
                       v = (a[31] != b[31]) && (r[31] != a[31]);
                   end
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            4'd11: r = a + 32'd1;
            4'd12: r = a - 32'd1;
            4'd13: r = b;
            default: r = 32'hDEADBEEF;
        endcase
        return {r[31], r == '0, v, c, r};
    endfunction

    // Expected response {err, op, flags, out} for one accepted command.
    function automatic logic [40:0] resp_of(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic cin);
        logic [35:0] f;
        f = alu_f(a, b, op, cin);
        return (op >= 4'd14) ? {1'b1, op, 36'b0} : {1'b0, op, f};
    endfunction

    // Result appears LAT-1 edges after the inputs change, so it is valid on the LAT-th edge.
    logic [35:0] pipe [LAT-1];
    always_ff @(posedge clk) begin
        pipe[0] <= alu_f(alu_a, alu_b, alu_op, alu_cin);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign {alu_n, alu_z, alu_v, alu_c, alu_out} = pipe[LAT-2];

    task automatic chk(input string tag, input logic [40:0] got, input logic [40:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic        hs, ps;
        logic [40:0] e;
        hs = rsp_valid && rsp_ready;
        ps = cmd_valid && cmd_ready;
        if (ps) exp_q.push_back(resp_of(cmd_a, cmd_b, cmd_op, cmd_cin));
        if (rsp_valid) begin
            e = exp_q.size() > 0 ? exp_q[0] : '1;
            chk("rsp", {rsp_err, rsp_op, rsp_flags, rsp_out}, e);
        end
        chk("alu_op_legal", 41'(alu_op >= 4'd14), 41'(0));
        @(posedge clk);
        #1;
        acc = ps;
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic cin);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic cin);
        drive(a, b, op, cin);
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) cycle();
        chk("send_accept", 41'(acc), 41'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 50 && !rsp_valid; i++) cycle();
        chk("rsp_wait", 41'(rsp_valid), 41'(1));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
        chk("drain_empty", 41'(exp_q.size()), 41'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        chk("reset_alu", 41'({alu_a, alu_b, alu_op, alu_cin} != '0), 41'(0));
        chk("reset_rsp", {rsp_err, rsp_op, rsp_flags, rsp_out}, 41'(0));
        chk("reset_ctl", 41'({rsp_valid, busy, fifo_count}), 41'(0));
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 41'(cmd_ready), 41'(1));

        // Latency of a single command into an idle block.
        send(32'h0A0A0A0A, 32'h0A0A0A0A, 4'd0, 1'b0);
        chk("alu_a_before_issue", 41'(alu_a), 41'(0));
        cycle();
        chk("alu_a_issued", 41'(alu_a), 41'(32'h0A0A0A0A));
        chk("alu_b_issued", 41'(alu_b), 41'(32'h0A0A0A0A));
        chk("busy_wait", 41'({busy, fifo_count}), 41'({1'b1, 3'd0}));
        repeat (3) cycle();
        chk("rsp_not_yet", 41'(rsp_valid), 41'(0));
        cycle();
        chk("rsp_on_time", 41'(rsp_valid), 41'(1));
        chk("rsp1_fields", {rsp_err, rsp_op, rsp_flags, rsp_out}, {1'b0, 4'd0, 4'b0100, 32'h0});
        rsp_ready = 1'b1;
        cycle();
        chk("rsp_dropped", 41'(rsp_valid), 41'(0));

        // Add with carry out, then subtract going negative.
        send(32'hFFFFFFFF, 32'h00000001, 4'd5, 1'b0);
        wait_rsp();
        chk("add_fields", {rsp_err, rsp_op, rsp_flags, rsp_out}, {1'b0, 4'd5, 4'b0101, 32'h0});
        cycle();
        send(32'd5, 32'd7, 4'd7, 1'b0);
        wait_rsp();
        chk("sub_out", 41'(rsp_out), 41'(32'hFFFFFFFE));
        chk("sub_n", 41'(rsp_flags[3]), 41'(1));
        cycle();

        // Back-pressure fills the FIFO behind one in-flight command.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send($urandom, $urandom, 4'($urandom_range(0, 13)), 1'($urandom_range(0, 1)));
        chk("full_ready", 41'(cmd_ready), 41'(0));
        chk("full_count", 41'(fifo_count), 41'(4));
        repeat (10) cycle();
        chk("full_hold", 41'({rsp_valid, fifo_count}), 41'({1'b1, 3'd4}));
        rsp_ready = 1'b1;
        drain(100);

        // Illegal op between two adds.
        send(32'd100, 32'd23, 4'd5, 1'b1);
        send(32'h12345678, 32'h9ABCDEF0, 4'd14, 1'b0);
        send(32'h7FFFFFFF, 32'd1, 4'd5, 1'b0);
        wait_rsp();
        chk("pre_illegal", {rsp_err, rsp_op, rsp_out[7:0], 28'b0}, {1'b0, 4'd5, 8'd124, 28'b0});
        cycle();
        wait_rsp();
        chk("illegal_rsp", {rsp_err, rsp_op, rsp_flags, rsp_out}, {1'b1, 4'd14, 36'b0});
        cycle();
        wait_rsp();
        chk("post_illegal", {rsp_err, rsp_flags, rsp_out}, {1'b0, 4'b1010, 32'h80000000});
        drain(50);

        // Asynchronous reset while waiting with three commands queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send($urandom, $urandom, 4'($urandom_range(0, 13)), 1'b0);
        chk("pre_reset_state", 41'({busy, rsp_valid, fifo_count}), 41'({1'b1, 1'b0, 3'd3}));
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_ctl", 41'({rsp_valid, busy, fifo_count}), 41'(0));
        chk("async_rst_alu", 41'({alu_a, alu_b, alu_op, alu_cin} != '0), 41'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) cycle();
        chk("no_stale", 41'({rsp_valid, fifo_count}), 41'(0));

        // Push on the same edge as a pop with two entries held.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 4'($urandom_range(0, 13)), 1'b1);
        wait_rsp();
        chk("two_held", 41'(fifo_count), 41'(2));
        rsp_ready = 1'b1;
        cycle();
        drive($urandom, $urandom, 4'd11, 1'b0);
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        chk("pushpop_acc", 41'(acc), 41'(1));
        chk("pushpop_count", 41'(fifo_count), 41'(2));
        drain(100);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            drive($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            rsp_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain(600);
        cycle();
        chk("final_idle", 41'({busy, fifo_count}), 41'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
